// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_fifo
// Description : Buffered UART transmitter. Bytes written from fabric logic are
//               queued in a circular FIFO and sent as 8N1 frames on o_tx.
//               Queued bytes go out back-to-back with no idle gap.
//               Optional even parity (8E1) with macro SERIAL_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_fifo #(
  parameter int CLK_FREQ   = 16_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int c_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int c_CW    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [c_CW-1:0]       c_RELOAD   = c_CW'(c_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   c_FULL_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [7:0]            w_head;

  // Transmitter state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_nxt;
  logic [c_CW-1:0]       r_baud;
  logic [c_CW-1:0]       w_baud_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
`ifdef SERIAL_TX_PARITY_EN
  logic                  r_parity;
`endif

  // A write into a full FIFO is dropped even when a pop frees a slot this cycle
  assign w_push      = i_wr & ~r_full;
  assign w_head      = r_mem[r_rptr];
  assign w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(w_push) - (DEPTH_LOG2 + 1)'(w_pop);

  // Byte storage; copied at enqueue so later i_data changes do not matter
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers, occupancy count and registered full/empty flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Transmitter state register; reset drives the line idle immediately
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_baud  <= w_baud_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the byte, captured as it leaves the FIFO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_head;
    end
  end
`endif

  // Next-state logic: bit boundaries happen when the baud counter hits zero
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = r_baud;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = c_RELOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_baud == '0) begin
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = c_RELOAD;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud - c_CW'(1);
        end
      end
      S_DATA: begin
        if (r_baud == '0) begin
          w_baud_nxt = c_RELOAD;
          if (r_bit == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            w_tx_nxt    = r_parity;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud - c_CW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (r_baud == '0) begin
          w_tx_nxt    = 1'b1;
          w_baud_nxt  = c_RELOAD;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud - c_CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (r_baud == '0) begin
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_baud_nxt  = c_RELOAD;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - c_CW'(1);
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_busy  = (r_state != S_IDLE);
  assign o_tx    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_fifo
// Description : Self-checking bench for serial_tx_fifo. A queue-and-timeline
//               model predicts the line and flags every cycle; a line decoder
//               recovers transmitted bytes. Directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_fifo;

  localparam int CLK_FREQ   = 16_000;
  localparam int BAUD_RATE  = 1_200;
  localparam int DEPTH_LOG2 = 2;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] data;
  logic       o_full, o_empty, o_busy, o_tx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  serial_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_wr   (wr),
    .i_data (data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_busy (o_busy),
    .o_tx   (o_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line level of frame position idx for byte b
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef SERIAL_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic [7:0] pop_log[$];
  logic [7:0] rx_log[$];
  logic       m_busy  = 1'b0;
  int         m_k     = 0;
  logic [7:0] m_byte  = 8'h00;
  logic       m_tx    = 1'b1;
  logic       m_empty = 1'b1;
  logic       m_full  = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_wr_ok;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_k    = 0;
      m_tx   = 1'b1;
    end else begin
      m_wr_ok = wr && (mq.size() < DEPTH);
      if (m_busy) begin
        m_k++;
        if (m_k == FB * DIV) m_busy = 1'b0;
      end
      if (!m_busy && mq.size() > 0) begin
        m_byte = mq.pop_front();
        pop_log.push_back(m_byte);
        m_busy = 1'b1;
        m_k    = 0;
      end
      if (m_wr_ok) mq.push_back(data);
      m_tx = m_busy ? frame_bit(m_byte, m_k / DIV) : 1'b1;
    end
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    m_valid = 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx",    o_tx,    m_tx);
      chk("busy",  o_busy,  m_busy);
      chk("empty", o_empty, m_empty);
      chk("full",  o_full,  m_full);
    end
  end

  // ---------------- line decoder ----------------
  logic       d_busy = 1'b0;
  logic       d_prev = 1'b1;
  int         d_cnt  = 0;
  int         d_idx;
  logic [7:0] d_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      d_busy = 1'b0;
      d_prev = 1'b1;
    end else begin
      if (!d_busy) begin
        if (d_prev && !o_tx) begin
          d_busy = 1'b1;
          d_cnt  = 0;
          d_byte = 8'h00;
        end
      end else begin
        d_cnt++;
        if (d_cnt % DIV == DIV / 2) begin
          d_idx = d_cnt / DIV;
          if (d_idx >= 1 && d_idx <= 8) d_byte[d_idx-1] = o_tx;
`ifdef SERIAL_TX_PARITY_EN
          if (d_idx == 9) chk("parity_bit", o_tx, ^d_byte);
`endif
          if (d_idx == FB - 1) begin
            chk("stop_bit", o_tx, 1);
            rx_log.push_back(d_byte);
            d_busy = 1'b0;
          end
        end
      end
      d_prev = o_tx;
    end
  end

  // ---------------- stimulus ----------------
  logic [FB-1:0] c_k_frame;
  int            pct;

  initial begin
    rst_n = 1'b0; wr = 1'b1; data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_tx",    o_tx,    1);
    chk("rst_busy",  o_busy,  0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full",  o_full,  0);
    rst_n = 1'b1; wr = 1'b0;
    @(negedge clk);
    chk("rst_nothing_queued", o_empty, 1);
    repeat (5) @(negedge clk);

    // Single byte 'K'; line pattern LSB first, start and stop
`ifdef SERIAL_TX_PARITY_EN
    c_k_frame = 11'b1_0_01001011_0;
`else
    c_k_frame = 10'b1_01001011_0;
`endif
    rx_log.delete();
    wr = 1'b1; data = 8'h4B;
    @(negedge clk);                       // after edge N
    wr = 1'b0; data = 8'hFF;
    chk("k_empty_after_write", o_empty, 0);
    chk("k_tx_before_pop",     o_tx,    1);
    @(negedge clk);                       // after N+1
    chk("k_tx_start", o_tx,    0);
    chk("k_busy",     o_busy,  1);
    chk("k_empty",    o_empty, 1);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < FB; i++) begin
      chk("k_bit", o_tx, c_k_frame[i]);
      if (i < FB - 1) repeat (DIV) @(negedge clk);
    end
    repeat (DIV - 1 - DIV / 2) @(negedge clk);  // after N+FB*DIV
    chk("k_busy_last", o_busy, 1);
    @(negedge clk);
    chk("k_busy_drop", o_busy, 0);
    repeat (20) @(negedge clk);
    chk("k_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("k_rx_byte", rx_log[0], 8'h4B);

    // Back-to-back frames
    rx_log.delete();
    wr = 1'b1; data = 8'h4B;
    @(negedge clk);
    data = 8'h55;
    @(negedge clk);                       // after N+1
    wr = 1'b0;
    repeat (FB * DIV - 1) @(negedge clk);
    chk("b2b_stop_end", o_tx, 1);
    @(negedge clk);
    chk("b2b_second_start", o_tx, 0);
    chk("b2b_busy", o_busy, 1);
    repeat (FB * DIV + 20) @(negedge clk);
    chk("b2b_rx_count", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      chk("b2b_rx0", rx_log[0], 8'h4B);
      chk("b2b_rx1", rx_log[1], 8'h55);
    end

    // Full / overflow: 6 writes, the last dropped
    rx_log.delete();
    for (int i = 1; i <= 6; i++) begin
      wr = 1'b1; data = 8'(i);
      @(negedge clk);
      if (i == 4) chk("ovf_not_full_4", o_full, 0);
      if (i == 5) chk("ovf_full_5",     o_full, 1);
    end
    wr = 1'b0;
    repeat (5 * FB * DIV + 40) @(negedge clk);
    chk("ovf_rx_count", rx_log.size(), 5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++)
      chk("ovf_rx_byte", rx_log[i], 32'(i + 1));

    // Randomized traffic against the model
    rx_log.delete();
    pop_log.delete();
    for (int blk = 0; blk < 6; blk++) begin
      pct = $urandom_range(2, 95);
      for (int c = 0; c < 500; c++) begin
        wr   = ($urandom_range(0, 99) < pct);
        data = 8'($urandom);
        @(negedge clk);
      end
    end
    wr = 1'b0;
    repeat ((DEPTH + 1) * FB * DIV + 40) @(negedge clk);
    chk("rnd_rx_count", rx_log.size(), pop_log.size());
    for (int i = 0; i < rx_log.size() && i < pop_log.size(); i++)
      chk("rnd_rx_byte", rx_log[i], pop_log[i]);

    // Reset in data bit 3 with two bytes queued
    rx_log.delete();
    wr = 1'b1; data = 8'h4B;
    @(negedge clk);
    data = 8'h11;
    @(negedge clk);
    data = 8'h22;
    @(negedge clk);                       // after N+2
    wr = 1'b0;
    repeat (57) @(negedge clk);           // after N+59, inside bit 3
    chk("mrst_busy_before", o_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_tx",    o_tx,    1);
    chk("mrst_busy",  o_busy,  0);
    chk("mrst_empty", o_empty, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FB * DIV) @(negedge clk);
    chk("mrst_no_frames", rx_log.size(), 0);
    chk("mrst_idle",      o_busy,        0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- Buffered UART transmitter. Accepts bytes from fabric logic into an internal FIFO and serialises them as 8N1 frames on o_tx.
- Companion to serial_rx: its line output feeds an external host or a serial_rx instance in loopback benches.
- Removes the need for callers to poll a busy flag per byte. Back-to-back queued bytes go out with no idle gap.

Parameters:
- CLK_FREQ, 16_000_000, i_clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s. Bit period DIV = CLK_FREQ / BAUD_RATE, using integer truncation.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_wr  in  1  write strobe; one byte is enqueued per cycle while high and not full.
- i_data  in  8  byte to enqueue, sampled when i_wr=1.
- o_full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- o_empty  out  1  FIFO holds 0 bytes.
- o_busy  out  1  a frame is on the line (FSM not IDLE).
- o_tx  out  1  serial line output, registered, idle high.

Behaviour:
- Reset (i_rst_n=0 at a posedge):
  - o_tx=1, o_busy=0, o_empty=1, o_full=0.
  - FIFO pointers and count are zeroed; the baud counter is zeroed; FSM goes to IDLE.
  - Reset mid-frame aborts the frame. o_tx is high from the first edge with reset low, and the queued bytes are discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read and write pointers that wrap naturally, plus a (DEPTH_LOG2+1)-bit count.
  - Write: i_wr=1 and o_full=0 stores i_data and increments the count at that edge.
  - i_wr=1 while o_full=1: the write is dropped silently, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: both happen and the count is unchanged.
  - o_full and o_empty are registered and derived from the next count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if o_empty=0, pop the head byte into an 8-bit shift register, drive o_tx=0, load the baud counter with DIV-1, and go to START.
  - START: hold o_tx=0 for DIV cycles. Then drive o_tx=shift[0], set bit index to 0, and go to DATA.
  - DATA: hold each bit for DIV cycles, LSB first, shifting right.
    - After bit 7, drive o_tx=1 and go to STOP.
    - With SERIAL_TX_PARITY_EN defined, go through PARITY first (see Optional Feature).
  - STOP: hold o_tx=1 for DIV cycles. Then:
    - if the FIFO is non-empty, pop and start the next frame immediately (o_tx=0 on the next cycle);
    - otherwise go to IDLE.
- Latency:
  - A write at edge N into an empty, idle block gives o_empty=0 after N.
  - The FSM pops at N+1, so o_tx falls at N+1.
  - o_busy=1 from N+1 until the edge at which the FSM re-enters IDLE.
- Frame timing: every bit, including start and stop, is exactly DIV cycles. An 8N1 frame is 10*DIV cycles. A byte stream is continuous at 10*DIV cycles per byte.
- Baud counter: a down-counter of width $clog2(DIV). It reloads DIV-1 on every bit boundary; the advance fires when the count reaches 0.
- i_data is copied at enqueue, so changes after the write edge do not affect the frame.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits, computed at pop) for DIV cycles.
  - Frame becomes 8E1, 11*DIV cycles.
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10*DIV cycles.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_wr=1 -> o_tx=1, o_busy=0, o_empty=1, o_full=0; nothing enqueued.
- Single byte: CLK_FREQ=16_000, BAUD_RATE=1_200 (DIV=13); write 0x4B ('K') at edge N.
  - o_tx=0 for 13 cycles from N+1, then bits 1,1,0,1,0,0,1,0 for 13 cycles each, then 1.
  - o_busy drops at N+1+130; o_empty=1 after N+1.
- Back-to-back: write 0x4B then 0x55 on consecutive edges -> the second start bit begins exactly 130 cycles after the first, with no extra idle cycle; a serial_rx loopback outputs 0x4B then 0x55.
- Full/overflow: DEPTH_LOG2=2; write 6 bytes 0x01..0x06 on consecutive cycles while the first frame is active.
  - o_full=1 after the 5th write (1 popped plus 4 queued).
  - 0x06 is dropped; 0x01..0x05 are transmitted in order.
- Reset mid-frame: assert reset during bit 3 of 0x4B with 2 bytes queued -> o_tx=1 from that edge, o_empty=1, no further frames after release.
- Parity (SERIAL_TX_PARITY_EN): 0x4B (four 1s) -> parity bit 0; 0x4A -> parity bit 1; frame length 143 cycles at DIV=13.
